// File: rtl/rv32_execute_if.sv
// rtl/rv32_execute_if.sv - execute-stage bundle: decode/hazard inputs, memory-stage outputs
interface rv32_execute_if;
    logic        stall_in;
    logic        flush_in;
    logic        valid_in;
    logic        exception_in;
    logic [3:0]  exception_cause_in;
    logic [3:0]  alu_op_in;
    logic        alu_src1_pc_in;
    logic        alu_src2_imm_in;
    logic        branch_src_rs1_in;
    logic        muldiv_in;
    logic [2:0]  muldiv_op_in;
    logic [31:0] pc_in;
    logic [31:0] rs1_value_in;
    logic [31:0] rs2_value_in;
    logic [31:0] imm_value_in;
    logic        read_in;
    logic        write_in;
    logic [1:0]  width_in;
    logic        zero_extend_in;
    logic        csr_read_in;
    logic        csr_write_in;
    logic [1:0]  csr_write_op_in;
    logic        csr_src_in;
    logic [1:0]  branch_op_in;
    logic        ecall_in;
    logic        ebreak_in;
    logic        mret_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic        branch_predicted_taken_in;
    logic [11:0] csr_in;

    logic        read_out;
    logic        write_out;
    logic [1:0]  width_out;
    logic        zero_extend_out;
    logic        csr_read_out;
    logic        csr_write_out;
    logic [1:0]  csr_write_op_out;
    logic        csr_src_out;
    logic [1:0]  branch_op_out;
    logic        ecall_out;
    logic        ebreak_out;
    logic        mret_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic        branch_predicted_taken_out;
    logic [11:0] csr_out;
    logic [31:0] rs1_value_out;
    logic [31:0] rs2_value_out;
    logic [31:0] imm_value_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        exception_out;
    logic [3:0]  exception_cause_out;
    logic [31:0] result_out;
    logic [31:0] branch_pc_out;
    logic        branch_misaligned_out;
    logic        busy_out;

    modport slave (
        input  stall_in, flush_in, valid_in, exception_in, exception_cause_in, alu_op_in,
               alu_src1_pc_in, alu_src2_imm_in, branch_src_rs1_in, muldiv_in, muldiv_op_in,
               pc_in, rs1_value_in, rs2_value_in, imm_value_in, read_in, write_in, width_in,
               zero_extend_in, csr_read_in, csr_write_in, csr_write_op_in, csr_src_in,
               branch_op_in, ecall_in, ebreak_in, mret_in, rd_in, rd_write_in,
               branch_predicted_taken_in, csr_in,
        output read_out, write_out, width_out, zero_extend_out, csr_read_out, csr_write_out,
               csr_write_op_out, csr_src_out, branch_op_out, ecall_out, ebreak_out, mret_out,
               rd_out, rd_write_out, branch_predicted_taken_out, csr_out, rs1_value_out,
               rs2_value_out, imm_value_out, pc_out, valid_out, exception_out,
               exception_cause_out, result_out, branch_pc_out, branch_misaligned_out, busy_out
    );

    modport master (
        output stall_in, flush_in, valid_in, exception_in, exception_cause_in, alu_op_in,
               alu_src1_pc_in, alu_src2_imm_in, branch_src_rs1_in, muldiv_in, muldiv_op_in,
               pc_in, rs1_value_in, rs2_value_in, imm_value_in, read_in, write_in, width_in,
               zero_extend_in, csr_read_in, csr_write_in, csr_write_op_in, csr_src_in,
               branch_op_in, ecall_in, ebreak_in, mret_in, rd_in, rd_write_in,
               branch_predicted_taken_in, csr_in,
        input  read_out, write_out, width_out, zero_extend_out, csr_read_out, csr_write_out,
               csr_write_op_out, csr_src_out, branch_op_out, ecall_out, ebreak_out, mret_out,
               rd_out, rd_write_out, branch_predicted_taken_out, csr_out, rs1_value_out,
               rs2_value_out, imm_value_out, pc_out, valid_out, exception_out,
               exception_cause_out, result_out, branch_pc_out, branch_misaligned_out, busy_out
    );
endinterface

// File: rtl/rv32_execute.sv
// rtl/rv32_execute.sv - rv32 execute stage: ALU, branch target, optional M-extension
// Define RV32_M_EXT_EN to build the multiplier and iterative divider; otherwise muldiv traps as illegal.
module rv32_execute #(
    parameter int DIV_BITS = 1
) (
    input logic           clk,
    input logic           reset,
    rv32_execute_if.slave ex
);
    logic [31:0] op1, op2, alu_result, target_base, target_sum, target;
    logic [4:0]  shamt;
    logic        busy, done_load, bubble, exc_d;
    logic [3:0]  cause_d;
    logic [31:0] res_d;

    assign op1   = ex.alu_src1_pc_in  ? ex.pc_in        : ex.rs1_value_in;
    assign op2   = ex.alu_src2_imm_in ? ex.imm_value_in : ex.rs2_value_in;
    assign shamt = op2[4:0];

    always_comb begin
        alu_result = '0;
        case (ex.alu_op_in)
            4'd0:    alu_result = op1 + op2;
            4'd1:    alu_result = op1 - op2;
            4'd2:    alu_result = op1 & op2;
            4'd3:    alu_result = op1 | op2;
            4'd4:    alu_result = op1 ^ op2;
            4'd5:    alu_result = {31'b0, $signed(op1) < $signed(op2)};
            4'd6:    alu_result = {31'b0, op1 < op2};
            4'd7:    alu_result = op1 << shamt;
            4'd8:    alu_result = op1 >> shamt;
            4'd9:    alu_result = $signed(op1) >>> shamt;
            4'd10:   alu_result = op2;
            4'd11:   alu_result = ex.pc_in + 32'd4;
            default: alu_result = '0;
        endcase
    end

    // JALR targets drop bit 0; PC-relative targets keep it so misalignment stays visible.
    assign target_base = ex.branch_src_rs1_in ? ex.rs1_value_in : ex.pc_in;
    assign target_sum  = target_base + ex.imm_value_in;
    assign target      = {target_sum[31:1], target_sum[0] & ~ex.branch_src_rs1_in};

`ifdef RV32_M_EXT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, isrem_q, isrem_d;
    logic        div_start, div_signed;
    logic [31:0] abs_a, abs_b, quo_step, rem_step, div_result;
    logic [32:0] shifted, mul_a, mul_b;
    logic [65:0] product;
    logic [31:0] mul_result;
    logic [1:0]  unused_product;

    assign mul_a   = {(ex.muldiv_op_in == 3'd1 || ex.muldiv_op_in == 3'd2) & ex.rs1_value_in[31],
                      ex.rs1_value_in};
    assign mul_b   = {(ex.muldiv_op_in == 3'd1) & ex.rs2_value_in[31], ex.rs2_value_in};
    assign product = $signed({{33{mul_a[32]}}, mul_a}) * $signed({{33{mul_b[32]}}, mul_b});
    assign mul_result     = (ex.muldiv_op_in == 3'd0) ? product[31:0] : product[63:32];
    assign unused_product = product[65:64];

    assign div_signed = ~ex.muldiv_op_in[0];
    assign div_start  = ex.valid_in & ex.muldiv_in & ex.muldiv_op_in[2] & ~ex.exception_in & ~ex.flush_in;
    assign abs_a      = (div_signed && ex.rs1_value_in[31]) ? -ex.rs1_value_in : ex.rs1_value_in;
    assign abs_b      = (div_signed && ex.rs2_value_in[31]) ? -ex.rs2_value_in : ex.rs2_value_in;

    always_comb begin
        quo_step = quo_q;
        rem_step = rem_q;
        shifted  = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            shifted  = {rem_step, quo_step[31]};
            quo_step = {quo_step[30:0], 1'b0};
            if (shifted >= {1'b0, dvs_q}) begin
                rem_step    = 32'(shifted - {1'b0, dvs_q});
                quo_step[0] = 1'b1;
            end else begin
                rem_step = shifted[31:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        isrem_d = isrem_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: if (div_start) begin
                busy    = 1'b1;
                isrem_d = ex.muldiv_op_in[1];
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
                if (ex.rs2_value_in == 32'd0) begin
                    quo_d   = 32'hFFFF_FFFF;
                    rem_d   = ex.rs1_value_in;
                    state_d = S_DONE;
                end else if (div_signed && ex.rs1_value_in == 32'h8000_0000 &&
                             ex.rs2_value_in == 32'hFFFF_FFFF) begin
                    quo_d   = 32'h8000_0000;
                    rem_d   = 32'd0;
                    state_d = S_DONE;
                end else begin
                    quo_d   = abs_a;
                    rem_d   = 32'd0;
                    dvs_d   = abs_b;
                    qneg_d  = div_signed & (ex.rs1_value_in[31] ^ ex.rs2_value_in[31]);
                    rneg_d  = div_signed & ex.rs1_value_in[31];
                    cnt_d   = 6'(32 / DIV_BITS);
                    state_d = S_RUN;
                end
            end
            S_RUN: if (ex.flush_in) begin
                state_d = S_IDLE;
            end else begin
                busy  = 1'b1;
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_DONE;
            end
            S_DONE: if (ex.flush_in || !ex.stall_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isrem_q <= isrem_d;
        end
    end

    assign div_result = isrem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
    assign done_load  = (state_q == S_DONE) & ~ex.flush_in;
    assign exc_d      = ex.exception_in;
    assign cause_d    = ex.exception_cause_in;
    assign res_d      = done_load ? div_result : (ex.muldiv_in ? mul_result : alu_result);
`else
    logic illegal;
    logic unused_muldiv_op;

    assign busy      = 1'b0;
    assign done_load = 1'b0;
    assign illegal   = ex.valid_in & ex.muldiv_in;
    assign exc_d     = ex.exception_in | illegal;
    assign cause_d   = (illegal && !ex.exception_in) ? 4'd2 : ex.exception_cause_in;
    assign res_d     = alu_result;
    assign unused_muldiv_op = ^ex.muldiv_op_in;
`endif

    assign ex.busy_out = busy;
    assign bubble      = ex.flush_in | busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex.valid_out                  <= 1'b0;
            ex.exception_out              <= 1'b0;
            ex.exception_cause_out        <= '0;
            ex.result_out                 <= '0;
            ex.branch_pc_out              <= '0;
            ex.branch_misaligned_out      <= 1'b0;
            ex.read_out                   <= 1'b0;
            ex.write_out                  <= 1'b0;
            ex.width_out                  <= '0;
            ex.zero_extend_out            <= 1'b0;
            ex.csr_read_out               <= 1'b0;
            ex.csr_write_out              <= 1'b0;
            ex.csr_write_op_out           <= '0;
            ex.csr_src_out                <= 1'b0;
            ex.branch_op_out              <= '0;
            ex.ecall_out                  <= 1'b0;
            ex.ebreak_out                 <= 1'b0;
            ex.mret_out                   <= 1'b0;
            ex.rd_out                     <= '0;
            ex.rd_write_out               <= 1'b0;
            ex.branch_predicted_taken_out <= 1'b0;
            ex.csr_out                    <= '0;
            ex.rs1_value_out              <= '0;
            ex.rs2_value_out              <= '0;
            ex.imm_value_out              <= '0;
            ex.pc_out                     <= '0;
        end else if (!ex.stall_in) begin
            ex.valid_out                  <= ~bubble & (done_load | ex.valid_in);
            ex.exception_out              <= ~bubble & exc_d;
            ex.exception_cause_out        <= cause_d;
            ex.result_out                 <= res_d;
            ex.branch_pc_out              <= target;
            ex.branch_misaligned_out      <= target[1];
            ex.read_out                   <= ex.read_in;
            ex.write_out                  <= ex.write_in;
            ex.width_out                  <= ex.width_in;
            ex.zero_extend_out            <= ex.zero_extend_in;
            ex.csr_read_out               <= ex.csr_read_in;
            ex.csr_write_out              <= ex.csr_write_in;
            ex.csr_write_op_out           <= ex.csr_write_op_in;
            ex.csr_src_out                <= ex.csr_src_in;
            ex.branch_op_out              <= ex.branch_op_in;
            ex.ecall_out                  <= ex.ecall_in;
            ex.ebreak_out                 <= ex.ebreak_in;
            ex.mret_out                   <= ex.mret_in;
            ex.rd_out                     <= ex.rd_in;
            ex.rd_write_out               <= ~bubble & ex.rd_write_in;
            ex.branch_predicted_taken_out <= ex.branch_predicted_taken_in;
            ex.csr_out                    <= ex.csr_in;
            ex.rs1_value_out              <= ex.rs1_value_in;
            ex.rs2_value_out              <= ex.rs2_value_in;
            ex.imm_value_out              <= ex.imm_value_in;
            ex.pc_out                     <= ex.pc_in;
        end
    end
endmodule

// File: tb/tb_rv32_execute.sv
// tb/tb_rv32_execute.sv - directed bench for rv32_execute
module tb_rv32_execute;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    rv32_execute_if ex_if ();

    rv32_execute #(.DIV_BITS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_if.stall_in = 0; ex_if.flush_in = 0; ex_if.valid_in = 0; ex_if.exception_in = 0;
        ex_if.exception_cause_in = 0; ex_if.alu_op_in = 0; ex_if.alu_src1_pc_in = 0;
        ex_if.alu_src2_imm_in = 0; ex_if.branch_src_rs1_in = 0; ex_if.muldiv_in = 0;
        ex_if.muldiv_op_in = 0; ex_if.pc_in = 0; ex_if.rs1_value_in = 0; ex_if.rs2_value_in = 0;
        ex_if.imm_value_in = 0; ex_if.read_in = 0; ex_if.write_in = 0; ex_if.width_in = 0;
        ex_if.zero_extend_in = 0; ex_if.csr_read_in = 0; ex_if.csr_write_in = 0;
        ex_if.csr_write_op_in = 0; ex_if.csr_src_in = 0; ex_if.branch_op_in = 0;
        ex_if.ecall_in = 0; ex_if.ebreak_in = 0; ex_if.mret_in = 0; ex_if.rd_in = 0;
        ex_if.rd_write_in = 0; ex_if.branch_predicted_taken_in = 0; ex_if.csr_in = 0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic use_imm);
        clear_in();
        ex_if.valid_in = 1; ex_if.rd_write_in = 1; ex_if.alu_op_in = op;
        ex_if.rs1_value_in = a; ex_if.rs2_value_in = b; ex_if.imm_value_in = b;
        ex_if.alu_src2_imm_in = use_imm;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic use_imm, input logic [31:0] exp);
        set_alu(op, a, b, use_imm);
        step();
        check(tag, ex_if.result_out, exp);
    endtask

`ifdef RV32_M_EXT_EN
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
        int busy_cycles;
        clear_in();
        ex_if.valid_in = 1; ex_if.rd_write_in = 1; ex_if.muldiv_in = 1;
        ex_if.muldiv_op_in = op; ex_if.rs1_value_in = a; ex_if.rs2_value_in = b;
        busy_cycles = 0;
        #1;
        for (int i = 0; i < 100 && ex_if.busy_out; i++) begin
            busy_cycles++;
            @(posedge clk);
            #2;
        end
        check({tag, "_busy"}, busy_cycles, exp_busy);
        step();
        check(tag, ex_if.result_out, exp);
        check({tag, "_valid"}, {31'b0, ex_if.valid_out}, 32'd1);
        clear_in();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_in();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, ex_if.valid_out}, 32'd0);
        check("rst_result", ex_if.result_out, 32'd0);
        check("rst_bpc", ex_if.branch_pc_out, 32'd0);
        check("rst_busy", {31'b0, ex_if.busy_out}, 32'd0);
        reset = 0;

        set_alu(4'd0, 32'd5, 32'd7, 1'b1);
        step();
        check("add", ex_if.result_out, 32'd12);
        check("add_valid", {31'b0, ex_if.valid_out}, 32'd1);
        check("add_rdw", {31'b0, ex_if.rd_write_out}, 32'd1);

        alu_vec("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
        alu_vec("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        alu_vec("sub", 4'd1, 32'd10, 32'd3, 1'b0, 32'd7);
        alu_vec("and", 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h00F0_000F);
        alu_vec("or", 4'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFFF0_0FFF);
        alu_vec("xor", 4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFF00_0FF0);
        alu_vec("sll", 4'd7, 32'd1, 32'h24, 1'b0, 32'h10);
        alu_vec("srl", 4'd8, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
        alu_vec("sra", 4'd9, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
        alu_vec("src2", 4'd10, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);

        set_alu(4'd0, 32'd0, 32'h10, 1'b1);
        ex_if.alu_src1_pc_in = 1; ex_if.pc_in = 32'h200;
        step();
        check("auipc", ex_if.result_out, 32'h210);

        clear_in();
        ex_if.valid_in = 1; ex_if.alu_op_in = 4'd11; ex_if.branch_src_rs1_in = 1;
        ex_if.rs1_value_in = 32'h1001; ex_if.imm_value_in = 32'd2; ex_if.pc_in = 32'h300;
        step();
        check("jalr_tgt", ex_if.branch_pc_out, 32'h1002);
        check("jalr_mis", {31'b0, ex_if.branch_misaligned_out}, 32'd1);
        check("jalr_link", ex_if.result_out, 32'h304);

        clear_in();
        ex_if.valid_in = 1; ex_if.alu_op_in = 4'd11; ex_if.pc_in = 32'h100;
        ex_if.imm_value_in = 32'd8; ex_if.rs1_value_in = 32'h5555;
        step();
        check("jal_tgt", ex_if.branch_pc_out, 32'h108);
        check("jal_mis", {31'b0, ex_if.branch_misaligned_out}, 32'd0);
        check("jal_link", ex_if.result_out, 32'h104);

        clear_in();
        ex_if.valid_in = 1; ex_if.read_in = 1; ex_if.width_in = 2'b10; ex_if.zero_extend_in = 1;
        ex_if.csr_read_in = 1; ex_if.csr_write_op_in = 2'b01; ex_if.csr_src_in = 1;
        ex_if.branch_op_in = 2'b11; ex_if.ebreak_in = 1; ex_if.branch_predicted_taken_in = 1;
        ex_if.rd_in = 5'h1B; ex_if.csr_in = 12'hABC; ex_if.rs2_value_in = 32'h1234_5678;
        ex_if.pc_in = 32'h0000_4444;
        step();
        check("pt_flags", {16'b0, ex_if.read_out, ex_if.write_out, ex_if.width_out,
              ex_if.zero_extend_out, ex_if.csr_read_out, ex_if.csr_write_out,
              ex_if.csr_write_op_out, ex_if.csr_src_out, ex_if.branch_op_out, ex_if.ecall_out,
              ex_if.ebreak_out, ex_if.mret_out, ex_if.branch_predicted_taken_out}, 32'h0000_ACF5);
        check("pt_rd", {27'b0, ex_if.rd_out}, 32'h1B);
        check("pt_csr", {20'b0, ex_if.csr_out}, 32'hABC);
        check("pt_rs2", ex_if.rs2_value_out, 32'h1234_5678);
        check("pt_pc", ex_if.pc_out, 32'h4444);

        set_alu(4'd0, 32'd5, 32'd7, 1'b1);
        step();
        set_alu(4'd1, 32'd10, 32'd3, 1'b0);
        ex_if.stall_in = 1;
        step();
        check("stall_hold", ex_if.result_out, 32'd12);
        ex_if.stall_in = 0;
        step();
        check("stall_release", ex_if.result_out, 32'd7);

        set_alu(4'd0, 32'd1, 32'd1, 1'b1);
        ex_if.exception_in = 1; ex_if.exception_cause_in = 4'd5;
        step();
        check("exc_out", {31'b0, ex_if.exception_out}, 32'd1);
        check("exc_cause", {28'b0, ex_if.exception_cause_out}, 32'd5);
        check("exc_valid", {31'b0, ex_if.valid_out}, 32'd1);

        set_alu(4'd0, 32'd1, 32'd1, 1'b1);
        ex_if.exception_in = 1; ex_if.flush_in = 1;
        step();
        check("flush_valid", {31'b0, ex_if.valid_out}, 32'd0);
        check("flush_rdw", {31'b0, ex_if.rd_write_out}, 32'd0);
        check("flush_exc", {31'b0, ex_if.exception_out}, 32'd0);

`ifdef RV32_M_EXT_EN
        clear_in();
        ex_if.valid_in = 1; ex_if.muldiv_in = 1; ex_if.muldiv_op_in = 3'd0;
        ex_if.rs1_value_in = 32'd3; ex_if.rs2_value_in = 32'd4;
        step();
        check("mul", ex_if.result_out, 32'd12);
        ex_if.muldiv_op_in = 3'd3; ex_if.rs1_value_in = 32'hFFFF_FFFF; ex_if.rs2_value_in = 32'hFFFF_FFFF;
        step();
        check("mulhu", ex_if.result_out, 32'hFFFF_FFFE);
        ex_if.muldiv_op_in = 3'd1;
        step();
        check("mulh", ex_if.result_out, 32'h0);
        ex_if.muldiv_op_in = 3'd2;
        step();
        check("mulhsu", ex_if.result_out, 32'hFFFF_FFFF);

        run_div("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_div("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_div("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        run_div("rem_neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        run_div("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_div("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_div("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        clear_in();
        ex_if.valid_in = 1; ex_if.rd_write_in = 1; ex_if.muldiv_in = 1; ex_if.muldiv_op_in = 3'd5;
        ex_if.rs1_value_in = 32'd100; ex_if.rs2_value_in = 32'd7;
        repeat (10) step();
        check("run_busy", {31'b0, ex_if.busy_out}, 32'd1);
        ex_if.flush_in = 1;
        #1;
        check("flush_run_busy", {31'b0, ex_if.busy_out}, 32'd0);
        step();
        check("flush_run_valid", {31'b0, ex_if.valid_out}, 32'd0);
        set_alu(4'd0, 32'd5, 32'd7, 1'b1);
        step();
        check("post_flush_add", ex_if.result_out, 32'd12);
        check("post_flush_valid", {31'b0, ex_if.valid_out}, 32'd1);

        clear_in();
        ex_if.valid_in = 1; ex_if.muldiv_in = 1; ex_if.muldiv_op_in = 3'd5;
        ex_if.rs1_value_in = 32'd100; ex_if.rs2_value_in = 32'd7;
        repeat (5) step();
        clear_in();
        ex_if.stall_in = 1;
        #2;
        reset = 1;
        #1;
        check("rst_mid_busy", {31'b0, ex_if.busy_out}, 32'd0);
        check("rst_mid_result", ex_if.result_out, 32'd0);
        check("rst_mid_valid", {31'b0, ex_if.valid_out}, 32'd0);
        step();
        reset = 0;
        clear_in();
        step();
`else
        clear_in();
        ex_if.valid_in = 1; ex_if.muldiv_in = 1; ex_if.muldiv_op_in = 3'd0;
        ex_if.rs1_value_in = 32'd3; ex_if.rs2_value_in = 32'd4;
        #1;
        check("mul_busy", {31'b0, ex_if.busy_out}, 32'd0);
        step();
        check("mul_illegal", {31'b0, ex_if.exception_out}, 32'd1);
        check("mul_cause", {28'b0, ex_if.exception_cause_out}, 32'd2);
        ex_if.muldiv_op_in = 3'd4;
        #1;
        check("div_busy", {31'b0, ex_if.busy_out}, 32'd0);
        ex_if.exception_in = 1; ex_if.exception_cause_in = 4'd7;
        step();
        check("mul_keep_cause", {28'b0, ex_if.exception_cause_out}, 32'd7);

        set_alu(4'd0, 32'd5, 32'd7, 1'b1);
        step();
        #3;
        reset = 1;
        #1;
        check("rst_async_result", ex_if.result_out, 32'd0);
        check("rst_async_valid", {31'b0, ex_if.valid_out}, 32'd0);
        step();
        reset = 0;
        clear_in();
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32_execute.md
Name: rv32_execute

Overview:
Execute stage of the rv32 pipeline, directly upstream of the memory stage.
- Computes the ALU result, which also serves as the load/store address and the branch-compare operand.
- Computes the branch/jump target and its misalignment flag.
- Performs M-extension multiply in one cycle and divide/remainder with an iterative FSM.
- Registers everything the memory stage consumes. Requests a pipeline stall from hazard while a divide runs.

Parameters:
DIV_BITS, 1, quotient bits resolved per cycle; legal values 1, 2, 4; RUN lasts 32/DIV_BITS cycles.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall_in  in  1  from hazard: downstream stalled, hold output registers
flush_in  in  1  from hazard: squash the instruction in this stage
valid_in  in  1  instruction valid
exception_in  in  1  upstream exception pending
exception_cause_in  in  4  upstream cause
alu_op_in  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA,10 SRC2,11 PC_PLUS_4
alu_src1_pc_in  in  1  operand1 = pc (1) or rs1 (0)
alu_src2_imm_in  in  1  operand2 = imm (1) or rs2 (0)
branch_src_rs1_in  in  1  target base = rs1 (JALR) or pc
muldiv_in  in  1  M-extension instruction
muldiv_op_in  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
pc_in, rs1_value_in, rs2_value_in, imm_value_in  in  32 each  operands
passthrough group  in/out  various  read, write, width[2], zero_extend, csr_read, csr_write, csr_write_op[2], csr_src, branch_op[2], ecall, ebreak, mret, rd[5], rd_write, branch_predicted_taken, csr[12], rs1_value, rs2_value, imm_value, pc; each *_in is registered to the matching *_out
valid_out  out  1  registered valid
exception_out  out  1  registered exception
exception_cause_out  out  4  registered cause
result_out  out  32  ALU or mul/div result
branch_pc_out  out  32  target
branch_misaligned_out  out  1  target[1] != 0
busy_out  out  1  combinational stall request to hazard

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, divider datapath registers 0.
- Non-divide instructions: 1-cycle latency. Output registers load on the clock edge when !stall_in.
- Shifts use operand2[4:0]. SLT/SLTU produce 0 or 1. PC_PLUS_4 = pc_in + 4.
- Target = (branch_src_rs1_in ? rs1 : pc) + imm. Bit0 of the target is cleared when branch_src_rs1_in = 1.
- MUL/MULH*: 33x33 signed product in one cycle; low or high 32 bits per op.
- Flush (!stall_in && flush_in): valid_out, rd_write_out and exception_out load 0.
- exception_in: the instruction is passed through with exception_out/exception_cause_out set, and no divide starts.

Divide FSM:
- IDLE -> RUN when valid_in && muldiv_in && op>=4 && !exception_in && !flush_in. Operands are latched; signed ops take absolute values and record result sign.
- Special cases skip RUN and go IDLE -> DONE:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- RUN: restoring division, DIV_BITS bits per cycle; counter 32/DIV_BITS down to 0, then -> DONE.
- DONE: apply sign. On the edge where !stall_in, load result_out, valid_out=1, then -> IDLE. Stay in DONE while stall_in.
- busy_out = 1 in the issue cycle (IDLE with a qualifying divide) and throughout RUN; 0 in DONE.
  - While busy_out && !stall_in, the output registers load a bubble (valid_out 0, rd_write_out 0).
- Latency with DIV_BITS=1: busy_out high for 33 cycles and the result registers at the end of cycle 34. Special cases: busy_out high 1 cycle, result at end of cycle 2.
- stall_in during RUN: iteration continues.
- flush_in in RUN or DONE: -> IDLE, busy_out drops the same cycle, bubble emitted.
- Reset mid-divide: immediate IDLE, busy_out 0.

Optional Feature:
RV32_M_EXT_EN
- Defined: multiplier and divide FSM present, as above.
- Undefined: no mul/div logic and busy_out tied 0. A valid muldiv_in instruction is registered with exception_out=1 and exception_cause_out=2 (illegal instruction). If exception_in is already set, the upstream cause is kept.

Test Plan:
- ADD, rs1=5, imm=7, alu_src2_imm_in=1 -> next edge result_out=12, valid_out=1; SLT rs1=-1, rs2=1 -> 1; SLTU same operands -> 0.
- DIVU 100/7, DIV_BITS=1 -> busy_out high exactly 33 cycles, result_out=14 at end of cycle 34; REMU -> 2; DIV -100/7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; busy_out high 1 cycle each.
- flush_in at RUN cycle 10 -> busy_out 0 that cycle, valid_out 0; an ADD issued next cycle completes normally. Reset asserted mid-RUN -> all outputs 0 immediately.
- JALR rs1=0x1001, imm=2 -> branch_pc_out=0x1002, branch_misaligned_out=1. JAL pc=0x100, imm=8 -> 0x108, misaligned 0, result_out (PC_PLUS_4)=0x104.
- RV32_M_EXT_EN undefined: MUL valid -> exception_out=1, cause 2, busy_out never asserts.
